// File: rtl/arith_batch_harness.sv
// Batch arithmetic harness: unpacks a 512-bit job line into operand pairs,
// streams them to a pipelined DUT and packs the results into one result line.
module arith_batch_harness #(
    parameter int DATA_LEN       = 32,
    parameter int MAX_PAIRS      = (512 - 64) / (2 * DATA_LEN),
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                soft_reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [511:0]        in_line,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [511:0]        out_line,
    output logic                dut_reset,
    output logic                dut_valid,
    input  logic                dut_ready,
    output logic [DATA_LEN-1:0] dut_a,
    output logic [DATA_LEN-1:0] dut_b,
    input  logic                dut_res_valid,
    input  logic [DATA_LEN-1:0] dut_result,
    output logic                busy
);

    localparam int IDX_W = $clog2(MAX_PAIRS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    n_q, n_d;
    logic [IDX_W-1:0]    issued_q, issued_d;
    logic [IDX_W-1:0]    received_q, received_d;
    logic [CNT_W-1:0]    cyc_q, cyc_d;
    logic [TO_W-1:0]     idle_q, idle_d;
    logic                tmo_q, tmo_d;
    logic                bad_q, bad_d;
    logic                spur_q, spur_d;
    logic                dut_reset_q, dut_reset_d;
    logic [DATA_LEN-1:0] op_a_q [MAX_PAIRS];
    logic [DATA_LEN-1:0] op_a_d [MAX_PAIRS];
    logic [DATA_LEN-1:0] op_b_q [MAX_PAIRS];
    logic [DATA_LEN-1:0] op_b_d [MAX_PAIRS];
    logic [DATA_LEN-1:0] res_q  [MAX_PAIRS];
    logic [DATA_LEN-1:0] res_d  [MAX_PAIRS];
    logic                in_job;
    logic                cap;
    logic                unused_hdr;

    assign unused_hdr = ^in_line[63:32];

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        issued_d    = issued_q;
        received_d  = received_q;
        cyc_d       = cyc_q;
        idle_d      = idle_q;
        tmo_d       = tmo_q;
        bad_d       = bad_q;
        spur_d      = spur_q;
        dut_reset_d = 1'b0;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_d       = res_q;
        in_job      = (state_q == ISSUE) || (state_q == DRAIN);
        cap         = dut_res_valid && in_job && (received_q != issued_q);

        if (in_job && (cyc_q != '1)) cyc_d = cyc_q + CNT_W'(1);

        if (cap) begin
            for (int i = 0; i < MAX_PAIRS; i++)
                if (received_q == IDX_W'(i)) res_d[i] = dut_result;
            received_d = received_q + IDX_W'(1);
        end
        // Results with no outstanding pair are dropped but flagged
        if (dut_res_valid && !cap && (state_q != IDLE)) spur_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    n_d        = '0;
                    issued_d   = '0;
                    received_d = '0;
                    cyc_d      = '0;
                    idle_d     = '0;
                    tmo_d      = 1'b0;
                    bad_d      = 1'b0;
                    spur_d     = 1'b0;
                    for (int i = 0; i < MAX_PAIRS; i++) begin
                        op_a_d[i] = in_line[64 + 2*i*DATA_LEN +: DATA_LEN];
                        op_b_d[i] = in_line[64 + (2*i+1)*DATA_LEN +: DATA_LEN];
                        res_d[i]  = '0;
                    end
                    if ((in_line[31:0] == 32'd0) ||
                        (in_line[31:0] > 32'(MAX_PAIRS))) begin
                        bad_d   = 1'b1;
                        state_d = OUT;
                    end else begin
                        n_d     = IDX_W'(in_line[31:0]);
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (dut_ready) begin
                    issued_d = issued_q + IDX_W'(1);
                    if (issued_d == n_q) begin
                        state_d = DRAIN;
                        idle_d  = '0;
                    end
                end
            end
            DRAIN: begin
                idle_d = dut_res_valid ? '0 : idle_q + TO_W'(1);
                if (received_q == n_q) begin
                    state_d = OUT;
                end else if (idle_d == TO_W'(TIMEOUT_CYCLES)) begin
                    tmo_d       = 1'b1;
                    dut_reset_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort outranks every other event in the cycle
        if (soft_reset) begin
            state_d     = IDLE;
            n_d         = '0;
            issued_d    = '0;
            received_d  = '0;
            cyc_d       = '0;
            idle_d      = '0;
            tmo_d       = 1'b0;
            bad_d       = 1'b0;
            spur_d      = 1'b0;
            dut_reset_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            issued_q    <= '0;
            received_q  <= '0;
            cyc_q       <= '0;
            idle_q      <= '0;
            tmo_q       <= 1'b0;
            bad_q       <= 1'b0;
            spur_q      <= 1'b0;
            dut_reset_q <= 1'b0;
            for (int i = 0; i < MAX_PAIRS; i++) begin
                op_a_q[i] <= '0;
                op_b_q[i] <= '0;
                res_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            issued_q    <= issued_d;
            received_q  <= received_d;
            cyc_q       <= cyc_d;
            idle_q      <= idle_d;
            tmo_q       <= tmo_d;
            bad_q       <= bad_d;
            spur_q      <= spur_d;
            dut_reset_q <= dut_reset_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_q       <= res_d;
        end
    end

    always_comb begin
        dut_a = '0;
        dut_b = '0;
        if (state_q == ISSUE) begin
            for (int i = 0; i < MAX_PAIRS; i++) begin
                if (issued_q == IDX_W'(i)) begin
                    dut_a = op_a_q[i];
                    dut_b = op_b_q[i];
                end
            end
        end
    end

    always_comb begin
        out_line = '0;
        if (state_q == OUT) begin
            out_line[31:0]  = {28'd0, spur_q, bad_q, tmo_q, 1'b1};
            out_line[63:32] = 32'(cyc_q);
            for (int i = 0; i < MAX_PAIRS; i++)
                out_line[64 + i*DATA_LEN +: DATA_LEN] = res_q[i];
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == OUT);
    assign dut_valid = (state_q == ISSUE);
    assign dut_reset = dut_reset_q;

endmodule

// File: tb/tb_arith_batch_harness.sv
// Scoreboard bench for arith_batch_harness with a 2-stage multiplier model.
// Expected result lines are queued at issue and checked by an output monitor.
module tb_arith_batch_harness;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         soft_reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [511:0] in_line = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [511:0] out_line;
    logic         dut_reset;
    logic         dut_valid;
    logic         dut_ready = 1'b1;
    logic [31:0]  dut_a;
    logic [31:0]  dut_b;
    logic         dut_res_valid;
    logic [31:0]  dut_result;
    logic         busy;

    arith_batch_harness #(
        .DATA_LEN(32),
        .TIMEOUT_CYCLES(16),
        .CNT_W(32)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .soft_reset(soft_reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_line(in_line),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_line(out_line),
        .dut_reset(dut_reset),
        .dut_valid(dut_valid),
        .dut_ready(dut_ready),
        .dut_a(dut_a),
        .dut_b(dut_b),
        .dut_res_valid(dut_res_valid),
        .dut_result(dut_result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [511:0] line;
        logic [511:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] pa [7];
    logic [31:0] pb [7];
    logic [31:0] pp [7];

    localparam logic [511:0] ALL   = '1;
    localparam logic [511:0] NOCYC = ~(512'hFFFF_FFFF << 32);

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Multiplier model: two register stages, optional single-result drop
    logic        s1_v = 1'b0, s2_v = 1'b0;
    logic [31:0] s1_d = '0, s2_d = '0;
    int          acc_cnt = 0;
    int          drop_at = -1;
    logic        spur_inj = 1'b0;

    always @(posedge clk) begin
        if (reset || dut_reset) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            s1_v <= dut_valid && dut_ready && (acc_cnt != drop_at);
            s1_d <= dut_a * dut_b;
            s2_v <= s1_v;
            s2_d <= s1_d;
        end
        if (!reset && dut_valid && dut_ready) acc_cnt <= acc_cnt + 1;
    end

    assign dut_res_valid = s2_v | spur_inj;
    assign dut_result    = spur_inj ? 32'hDEAD_BEEF : s2_d;

    int ready_mode = 0;
    initial begin
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            dut_ready = (ready_mode == 0) ? 1'b1 : pat[3 - (k % 4)];
            k++;
        end
    end

    // Monitors: result-line scoreboard, issue order, pulse counters
    int iss_idx = 0;
    int iss_start = 0;
    logic iss_en = 1'b0;
    int dv_cnt = 0;
    int dr_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (dut_valid) dv_cnt++;
            if (dut_reset) dr_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 512'(out_valid), 512'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_line", out_line & e.mask, e.line & e.mask);
                end
            end
            if (iss_en && dut_valid) begin
                int k;
                k = iss_idx - iss_start;
                if (k < 7)
                    chk("issue_pair", {448'd0, dut_a, dut_b},
                        {448'd0, pa[k], pb[k]});
                else
                    chk("extra_issue", 512'(k), 512'd6);
            end
            if (dut_valid && dut_ready) iss_idx++;
        end
    end

    function automatic logic [511:0] mk_job(logic [31:0] n);
        logic [511:0] l;
        l = '0;
        l[31:0] = n;
        for (int i = 0; i < 7; i++) begin
            l[64 + 2*i*32 +: 32]     = pa[i];
            l[64 + (2*i+1)*32 +: 32] = pb[i];
        end
        return l;
    endfunction

    function automatic logic [511:0] mk_exp(logic [31:0] st,
                                            logic [31:0] cyc, int nres);
        logic [511:0] l;
        l = '0;
        l[31:0]  = st;
        l[63:32] = cyc;
        for (int i = 0; i < 7; i++)
            if (i < nres) l[64 + i*32 +: 32] = pp[i];
        return l;
    endfunction

    task automatic push(input logic [511:0] l, input logic [511:0] m);
        exp_t e;
        e.line = l;
        e.mask = m;
        exp_q.push_back(e);
    endtask

    task automatic send_job(input logic [511:0] l);
        int t;
        t = 0;
        @(negedge clk);
        in_line  = l;
        in_valid = 1'b1;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_wait", 512'd0, 512'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) chk("drain_timeout", 512'(exp_q.size()), 512'd0);
    endtask

    task automatic load_basic();
        pa = '{32'd3, 32'd7, 32'd65535, 32'd0, 32'd0, 32'd0, 32'd0};
        pb = '{32'd5, 32'd11, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0};
        pp = '{32'd15, 32'd77, 32'd131070, 32'd0, 32'd0, 32'd0, 32'd0};
    endtask

    task automatic load_seven();
        pa = '{32'd1, 32'd2, 32'd10, 32'd100, 32'd12, 32'd255, 32'd1000};
        pb = '{32'd1, 32'd3, 32'd10, 32'd200, 32'd12, 32'd255, 32'd1000};
        pp = '{32'd1, 32'd6, 32'd100, 32'd20000, 32'd144, 32'd65025,
               32'd1000000};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] e;
        int dv0, dr0;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_in_ready", 512'(in_ready), 512'd1);
        chk("rst_out_valid", 512'(out_valid), 512'd0);
        chk("rst_out_line", out_line, 512'd0);
        chk("rst_dut_valid", 512'(dut_valid), 512'd0);
        chk("rst_dut_ab", {448'd0, dut_a, dut_b}, 512'd0);
        chk("rst_dut_reset", 512'(dut_reset), 512'd0);
        chk("rst_busy", 512'(busy), 512'd0);

        // Basic job, 3 pairs back to back: 3 issue + 2 latency + 1 drain
        load_basic();
        push(mk_exp(32'h1, 32'd6, 3), ALL);
        send_job(mk_job(32'd3));
        wait_done();

        // Backpressure on all 7 pairs
        load_seven();
        ready_mode = 1;
        iss_start = iss_idx;
        iss_en = 1'b1;
        push(mk_exp(32'h1, 32'd0, 7), NOCYC);
        send_job(mk_job(32'd7));
        wait_done();
        chk("bp_issue_count", 512'(iss_idx - iss_start), 512'd7);
        iss_en = 1'b0;
        ready_mode = 0;

        // Output stall for 20 cycles
        pa = '{32'd6, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        pb = '{32'd7, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        pp = '{32'd42, 32'd81, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        e = mk_exp(32'h1, 32'd5, 2);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push(e, ALL);
        send_job(mk_job(32'd2));
        begin
            int t;
            t = 0;
            while (!out_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("stall_out_valid", 512'(out_valid), 512'd1);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_line", out_line, e);
            chk("stall_in_ready", 512'(in_ready), 512'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_hs_in_ready", 512'(in_ready), 512'd1);
        chk("post_hs_out_valid", 512'(out_valid), 512'd0);
        load_basic();
        push(mk_exp(32'h1, 32'd6, 3), ALL);
        send_job(mk_job(32'd3));
        chk("next_job_taken", 512'(busy), 512'd1);
        wait_done();

        // Bad counts: n=0 and n=8, no DUT traffic
        load_seven();
        pp = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        dv0 = dv_cnt;
        push(mk_exp(32'h5, 32'd0, 0), ALL);
        send_job(mk_job(32'd0));
        wait_done();
        push(mk_exp(32'h5, 32'd0, 0), ALL);
        send_job(mk_job(32'd8));
        wait_done();
        chk("bad_no_dut_valid", 512'(dv_cnt - dv0), 512'd0);

        // Timeout: second result dropped, 16 idle drain cycles
        pa = '{32'd4, 32'd8, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        pb = '{32'd4, 32'd8, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        pp = '{32'd16, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        dr0 = dr_cnt;
        drop_at = acc_cnt + 1;
        push(mk_exp(32'h3, 32'd19, 1), ALL);
        send_job(mk_job(32'd2));
        wait_done();
        chk("tmo_dut_reset_pulses", 512'(dr_cnt - dr0), 512'd1);
        drop_at = -1;

        // Abort in the middle of issue
        load_seven();
        send_job(mk_job(32'd7));
        repeat (2) @(posedge clk);
        #1;
        soft_reset = 1'b1;
        @(posedge clk);
        #1;
        soft_reset = 1'b0;
        chk("abort_dut_reset", 512'(dut_reset), 512'd1);
        chk("abort_busy", 512'(busy), 512'd0);
        chk("abort_dut_valid", 512'(dut_valid), 512'd0);
        chk("abort_out_valid", 512'(out_valid), 512'd0);
        @(posedge clk);
        #1;
        chk("abort_dut_reset_end", 512'(dut_reset), 512'd0);
        repeat (6) @(posedge clk);
        #1;

        // Clean job after abort, then spurious result in final drain cycle
        load_basic();
        push(mk_exp(32'h1, 32'd6, 3), ALL);
        send_job(mk_job(32'd3));
        wait_done();
        push(mk_exp(32'h9, 32'd6, 3), ALL);
        send_job(mk_job(32'd3));
        repeat (5) @(posedge clk);
        #1;
        spur_inj = 1'b1;
        @(posedge clk);
        #1;
        spur_inj = 1'b0;
        wait_done();

        repeat (3) @(posedge clk);
        chk("queue_empty", 512'(exp_q.size()), 512'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arith_batch_harness.md
Name: arith_batch_harness

Overview:
- Single-clock successor to the CSR-driven arithmetic test harness.
- Accepts one 512-bit job line holding up to MAX_PAIRS operand pairs and streams them into a pipelined arithmetic DUT (multiplier/divider) at up to one pair per cycle, honouring DUT backpressure.
- Collects results in order, then emits one 512-bit result line with a status word and cycle count.
- Sits between the host-line read/write logic and the DUT. No clock divider; DUT latency is arbitrary and handled by result counting plus a timeout.

Parameters:
- DATA_LEN, 32, operand/result width in bits; legal values 8, 16, 32.
- MAX_PAIRS, (512-64)/(2*DATA_LEN), maximum pairs per job line; 7 at default width.
- TIMEOUT_CYCLES, 1024, idle cycles allowed in DRAIN with no DUT result before the job is abandoned.
- CNT_W, 32, width of the per-job cycle counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- soft_reset  in  1  one-cycle abort request (CSR-driven)
- in_valid  in  1  job line valid
- in_ready  out  1  harness can accept a job line
- in_line  in  512  job line
- out_valid  out  1  result line valid
- out_ready  in  1  consumer accepts result line
- out_line  out  512  result line
- dut_reset  out  1  one-cycle DUT flush pulse
- dut_valid  out  1  operand pair valid
- dut_ready  in  1  DUT accepts pair
- dut_a  out  DATA_LEN  operand a
- dut_b  out  DATA_LEN  operand b
- dut_res_valid  in  1  DUT result valid
- dut_result  in  DATA_LEN  DUT result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_line=0, dut_valid=0, dut_a=0, dut_b=0, dut_reset=0, busy=0, all counters and flags 0.
- Job line format:
  - in_line[31:0] = n, the pair count.
  - Pair i: a at bit 64+2*i*DATA_LEN; b at bit 64+(2*i+1)*DATA_LEN.
- Result line format:
  - [31:0] = status: bit0 done=1, bit1 timeout, bit2 bad_count, bit3 spurious; other bits 0.
  - [63:32] = cycle count, truncated or zero-extended to 32 bits.
  - Result i at bit 64+i*DATA_LEN. Unwritten slots are 0.
- State machine:
  - IDLE: in_ready=1. On in_valid, capture in_line, clear issued/received counts, flags and cycle counter.
    - If n==0 or n>MAX_PAIRS: set bad_count and go to OUT (no DUT traffic).
    - Otherwise go to ISSUE.
  - ISSUE: dut_valid=1 with pair[issued]. On dut_valid&&dut_ready, issued++ and the next pair is presented the following cycle (back-to-back issue allowed). When the last pair is accepted, go to DRAIN. If dut_ready=0, a/b/valid hold stable.
  - DRAIN: dut_valid=0. Wait until received==n, then go to OUT.
  - OUT: out_valid=1 and out_line holds stable until out_ready. On out_valid&&out_ready, go to IDLE; in_ready returns to 1 the following cycle.
- Result capture (ISSUE and DRAIN): each dut_res_valid writes dut_result to slot[received], then received++. Results may arrive while still issuing.
- Cycle counter: increments every cycle from the cycle after job capture up to and including the cycle before OUT is entered, saturating at all-ones.
- Timeout: an idle counter resets on each dut_res_valid and on entry to DRAIN, and increments each DRAIN cycle. On reaching TIMEOUT_CYCLES:
  - set timeout;
  - pulse dut_reset for exactly one cycle;
  - go to OUT with the results received so far.
- Spurious results: dut_res_valid in IDLE or OUT, or when received==issued, is discarded. If it occurs during a job (ISSUE/DRAIN/OUT before acceptance), spurious is set. It never overwrites a slot or increments received.
- soft_reset (any state) aborts the job with no output line:
  - go to IDLE, drop out_valid and dut_valid;
  - pulse dut_reset for one cycle;
  - clear counters.
  - soft_reset has priority over every other event in the same cycle.
- reset has priority over soft_reset. dut_reset is not asserted by reset; the DUT shares reset.
- Simultaneous events:
  - A final dut_res_valid in the same cycle the idle counter hits TIMEOUT_CYCLES counts as a success: result captured, timeout not set.
  - in_valid while busy is ignored (in_ready=0).

Test Plan:
- Basic job: DUT = 2-stage multiplier, dut_ready=1, n=3, pairs (3,5),(7,11),(65535,2) -> status=0x1, results 15, 77, 131070, slots 3..6 zero, one out_valid handshake.
- Backpressure: n=7, dut_ready toggles 1,0,0,1 repeating -> dut_a/dut_b stable while stalled, each pair issued exactly once, results in order.
- Output stall: hold out_ready=0 for 20 cycles -> out_line constant, in_ready=0 throughout, next job accepted one cycle after handshake.
- Bad count: n=0, then n=8 -> status=0x5 for each, no dut_valid asserted, results zero.
- Timeout: DUT drops the 2nd result, n=2, TIMEOUT_CYCLES=16 -> dut_reset pulses once, status=0x3, slot0 valid, slot1 zero.
- Abort and spurious: soft_reset mid-ISSUE -> no out_valid, dut_reset pulse, IDLE next cycle; inject an extra dut_res_valid during DRAIN -> status bit3 set, results unchanged.
